// File: rtl/msg_reader.sv
// rtl/msg_reader.sv - streams RAM A bytes 0..MESSAGE_LENGTH-1 out on a valid/ready port
// Optional character check: define MSG_READER_CHAR_CHECK_EN.
module msg_reader #(
  parameter int MESSAGE_LENGTH = 32,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] aAddr,
  input  logic [7:0]            aOut,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  msg_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MESSAGE_LENGTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  start_ok;
  logic                  handshake;
  logic                  is_last;

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign handshake = (state_q == S_PRESENT) && out_ready;
  assign is_last   = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_FETCH;
      S_FETCH:        state_d = S_WAIT;
      S_WAIT:         state_d = S_PRESENT;
      S_PRESENT:      if (handshake) state_d = is_last ? S_DONE : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (start_ok) idx_d = '0;
    if (state_q == S_WAIT) begin
      data_d  = aOut;
      last_d  = is_last;
      valid_d = 1'b1;
    end
    // idx stops at the last index so aAddr never leaves the message range
    if (handshake) begin
      valid_d = 1'b0;
      if (is_last) last_d = 1'b0;
      else         idx_d  = idx_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    busy = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_PRESENT);
    done = (state_q == S_DONE);
  end

  assign aAddr     = idx_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

`ifdef MSG_READER_CHAR_CHECK_EN
  logic ok_q, ok_d;
  logic char_ok;

  assign char_ok = ((aOut >= 8'd97) && (aOut <= 8'd122)) || (aOut == 8'd32);

  always_comb begin
    ok_d = ok_q;
    if (start_ok)                            ok_d = 1'b1;
    else if (state_q == S_WAIT && !char_ok)  ok_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ok_q <= 1'b1;
    else       ok_q <= ok_d;
  end

  assign msg_ok = ok_q;
`else
  assign msg_ok = 1'b1;
`endif

endmodule

// File: tb/tb_msg_reader.sv
// tb/tb_msg_reader.sv - randomized directed bench for msg_reader against a message model
module tb_msg_reader;

  logic       clk = 1'b0;
  logic       m_reset, m_start, m_ready;
  logic [7:0] m_addr, m_rdata, m_data;
  logic       m_valid, m_last, m_busy, m_done, m_ok;
  logic [7:0] m_mem [256];

  logic       s_reset, s_start, s_ready;
  logic [3:0] s_addr;
  logic [7:0] s_rdata, s_data;
  logic       s_valid, s_last, s_busy, s_done, s_ok;
  logic [7:0] s_mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msg_reader #(.MESSAGE_LENGTH(32), .ADDR_WIDTH(8)) dut_main (
    .clk(clk), .reset(m_reset), .start(m_start), .aAddr(m_addr), .aOut(m_rdata),
    .out_data(m_data), .out_valid(m_valid), .out_ready(m_ready), .out_last(m_last),
    .busy(m_busy), .done(m_done), .msg_ok(m_ok)
  );

  msg_reader #(.MESSAGE_LENGTH(1), .ADDR_WIDTH(4)) dut_one (
    .clk(clk), .reset(s_reset), .start(s_start), .aAddr(s_addr), .aOut(s_rdata),
    .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready), .out_last(s_last),
    .busy(s_busy), .done(s_done), .msg_ok(s_ok)
  );

  // synchronous-read RAM models
  always @(posedge clk) m_rdata <= m_mem[m_addr];
  always @(posedge clk) s_rdata <= s_mem[s_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expected_ok();
`ifdef MSG_READER_CHAR_CHECK_EN
    for (int i = 0; i < 32; i++)
      if (!((m_mem[i] >= 8'd97 && m_mem[i] <= 8'd122) || m_mem[i] == 8'd32)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic load_random();
    for (int i = 0; i < 32; i++)
      m_mem[i] = ($urandom_range(0, 4) == 0) ? 8'd32 : 8'(97 + $urandom_range(0, 25));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pulse start and check the two-edge latency to the first valid byte
  task automatic start_run();
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    check("start_busy", m_busy, 1);
    check("start_done_clr", m_done, 0);
    check("start_addr0", m_addr, 0);
    check("lat_e1_valid", m_valid, 0);
    step();
    check("lat_e2_valid", m_valid, 0);
    step();
    check("lat_first_valid", m_valid, 1);
  endtask

  task automatic xfer(input int stall_at, input int restart_at, input int abort_at,
                      input bit rand_bp, output bit aborted);
    int k = 0;
    int cyc = 0;
    int stalled = 0;
    bit restarted = 1'b0;
    aborted = 1'b0;
    while (k < 32 && cyc < 3000) begin
      m_start = 1'b0;
      if (m_valid) begin
        if (k == abort_at) begin
          m_reset = 1'b1;
          #1;
          check("rst_valid", m_valid, 0);
          check("rst_addr", m_addr, 0);
          check("rst_busy", m_busy, 0);
          check("rst_done", m_done, 0);
          check("rst_last", m_last, 0);
          check("rst_data", m_data, 0);
          #2;
          m_reset = 1'b0;
          m_ready = 1'b0;
          aborted = 1'b1;
          return;
        end
        check("byte_data", m_data, m_mem[k]);
        check("byte_last", m_last, (k == 31));
        check("byte_addr", m_addr, 32'(k));
        check("byte_busy", m_busy, 1);
        if (k == restart_at && !restarted) begin
          m_start = 1'b1;
          restarted = 1'b1;
        end
        if (k == stall_at && stalled < 10) begin
          m_ready = 1'b0;
          stalled++;
        end else begin
          m_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
          if (m_ready) k++;
        end
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
    end
    m_start = 1'b0;
    m_ready = 1'b0;
    check("xfer_in_budget", 32'(cyc < 3000), 1);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, m_done, 1);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_msg_ok"}, m_ok, expected_ok());
  endtask

  initial begin
    string s;
    bit    ab;
    int    cyc;
    m_reset = 1'b1; m_start = 1'b0; m_ready = 1'b0;
    s_reset = 1'b1; s_start = 1'b0; s_ready = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(65 + $urandom_range(0, 25));
    for (int i = 0; i < 16; i++)  s_mem[i] = 8'($urandom_range(0, 255));
    step();
    step();
    m_reset = 1'b0;
    s_reset = 1'b0;
    step();

    check("reset_addr", m_addr, 0);
    check("reset_data", m_data, 0);
    check("reset_valid", m_valid, 0);
    check("reset_last", m_last, 0);
    check("reset_busy", m_busy, 0);
    check("reset_done", m_done, 0);
    check("reset_msg_ok", m_ok, 1);

    // run 1: fixed message, stall on byte 5, stray start at byte 10
    s = "attack at dawn";
    for (int i = 0; i < 32; i++) m_mem[i] = (i < s.len()) ? s[i] : 8'd32;
    m_mem[5] = 8'h63;
    start_run();
    xfer(5, 10, -1, 1'b0, ab);
    check_done("run1");

    // ready is ignored in DONE
    for (int i = 0; i < 5; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b0;
    check("done_hold", m_done, 1);
    check("done_hold_valid", m_valid, 0);

    // run 2: random message, reset while byte 17 is presented
    load_random();
    start_run();
    xfer(-1, -1, 17, 1'b1, ab);
    check("run2_aborted", ab, 1);
    step();
    check("post_rst_idle_busy", m_busy, 0);

    // run 3: upper-case byte at 20
    load_random();
    m_mem[20] = 8'h41;
    start_run();
    xfer(-1, -1, -1, 1'b1, ab);
    check_done("run3");

    // run 4: same position lower-case
    m_mem[20] = 8'h61;
    start_run();
    xfer(-1, -1, -1, 1'b1, ab);
    check_done("run4");

    // single-byte message
    s_mem[0] = 8'($urandom_range(0, 255));
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    cyc = 0;
    while (!s_valid && cyc < 20) begin
      check("one_addr_wait", s_addr, 0);
      step();
      cyc++;
    end
    check("one_latency", cyc, 2);
    check("one_data", s_data, s_mem[0]);
    check("one_last", s_last, 1);
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    check("one_done", s_done, 1);
    check("one_valid_clr", s_valid, 0);
    check("one_last_clr", s_last, 0);
    check("one_addr_end", s_addr, 0);
    check("one_busy", s_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_reader.md
Name: msg_reader

Overview:
- Read-side counterpart to the arcfour core's writes into the decrypted-message RAM (A).
- Once a decryption finishes, it walks RAM A from address 0 to MESSAGE_LENGTH-1 and streams each byte out on a valid/ready interface to a downstream consumer (UART TX or HEX display driver).
- It is the only agent driving A's read address while active.
- It owns no memory; it sequences reads against the RAM's one-cycle synchronous read latency.

Parameters:
- MESSAGE_LENGTH, 32, number of bytes to read (1..2**ADDR_WIDTH).
- ADDR_WIDTH, 8, width of RAM A address bus.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  level sampled each cycle; honoured only in IDLE (one cycle high suffices).
- aAddr  out  ADDR_WIDTH  read address to RAM A.
- aOut  in  8  RAM A read data; valid the cycle after aAddr is sampled by the RAM.
- out_data  out  8  current message byte.
- out_valid  out  1  out_data holds a byte not yet accepted.
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge.
- out_last  out  1  high with out_valid on byte index MESSAGE_LENGTH-1.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  high in DONE; cleared on next accepted start or reset.
- msg_ok  out  1  character-check result (see Optional Feature).

Behaviour:
- Reset (async, active-high) → state IDLE, idx=0, aAddr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, msg_ok=1. Takes effect mid-transfer with no completion of the in-flight byte.
- idx is an ADDR_WIDTH-bit register; aAddr is registered and always equals idx.
- State IDLE:
  - start=1 → FETCH, with idx=0 and done=0.
  - Otherwise stay.
- State DONE: behaves as IDLE (start → FETCH with idx=0, done=0). done stays high until then.
- State FETCH: aAddr=idx presented for one cycle; RAM samples it at the closing edge → WAIT.
- State WAIT: aOut valid. At the closing edge: out_data<=aOut, out_last<=(idx==MESSAGE_LENGTH-1), out_valid<=1 → PRESENT.
- State PRESENT: out_data, out_last, out_valid held stable until handshake.
  - Handshake, not last → out_valid<=0, idx<=idx+1 → FETCH.
  - Handshake, last → out_valid<=0, out_last<=0, done<=1 → DONE.
- Latency: start sampled at edge E0; first out_valid high after edge E2.
- Best-case throughput: 1 byte per 3 cycles (PRESENT/FETCH/WAIT).
- start while busy: ignored, no restart.
- out_ready high outside PRESENT: ignored.
- out_ready held low: indefinite stall; data and out_last must not change.
- idx never wraps: the transfer ends at MESSAGE_LENGTH-1.
- MESSAGE_LENGTH=1: the first byte carries out_last.
- aAddr is never driven beyond MESSAGE_LENGTH-1.
- busy = (state ∈ {FETCH, WAIT, PRESENT}).

Optional Feature:
- Macro: MSG_READER_CHAR_CHECK_EN.
- Defined:
  - msg_ok is set to 1 when start is accepted.
  - At each WAIT capture, msg_ok is cleared if aOut is not in 8'd97..8'd122 and not 8'd32.
  - Sticky until the next accepted start or reset. Meaningful when done=1.
- Undefined: msg_ok is tied to 1; no comparator logic is synthesised.

Test Plan:
- Preload A[0..31]="attack at dawn..." (lowercase/space), pulse start one cycle, out_ready=1 → 32 bytes emitted in address order; first out_valid 3 cycles after start; out_last only on byte 31; done=1 after the last handshake; msg_ok=1 with the macro defined.
- Backpressure: out_ready=0 for 10 cycles while byte 5 (A[5]=8'h63) is presented → out_data stays 8'h63 and out_valid stays 1 throughout; aAddr stays 5; next byte follows the handshake.
- start pulsed again at byte 10 → ignored; the sequence continues at 11 and completes at 31 with no restart.
- Assert reset while PRESENT holds byte 17 → outputs immediately return to reset values (out_valid=0, aAddr=0, busy=0, done=0); a later start restarts at address 0.
- With the macro defined, set A[20]=8'h41 ('A') → msg_ok=0 at done. A rerun with A[20]=8'h61 → msg_ok=1. With the macro undefined, msg_ok=1 in both runs.
- Parameter MESSAGE_LENGTH=1 → a single byte with out_last=1, then done; aAddr never leaves 0.
